// File: rtl/fp_stream_accumulator.sv
// fp_stream_accumulator: streaming FP32 packet summer.
//   Packets arrive over a valid/ready stream delimited by in_last. Each
//   accepted beat is added to the running total (acc = acc + x, in arrival
//   order) through one combinational fp_adder_single_cycle. The total and the
//   saturating beat count are held on a registered valid/ready output.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last   operand stream
//   out_valid/out_ready/out_sum/out_count result stream
//   busy                         packet in progress (ACC or HOLD)
// Optional feature: define FP_ACC_NAN_STICKY_EN to force the canonical quiet
//   NaN (32'h7FC00000) as the result of any packet that contained an
//   exponent-255 (Inf/NaN) beat.

// Combinational FP32 adder: round-to-nearest-even, gradual underflow,
// overflow to Inf, canonical quiet NaN for invalid operations.
module fp_adder_single_cycle (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [31:0] x, y;            // x has the larger magnitude
  logic [7:0]  ex, ey, d;
  logic [26:0] mx, my, my_sh;   // 24-bit significand + guard/round/sticky
  logic        stk;
  logic [27:0] s;
  logic [26:0] n;
  logic [4:0]  pos;
  logic [9:0]  e, lz, lim, sh;
  logic        up;
  logic [24:0] m;
  logic [9:0]  expf;

  assign a_nan = (&a[30:23]) & (|a[22:0]);
  assign b_nan = (&b[30:23]) & (|b[22:0]);
  assign a_inf = (&a[30:23]) & ~(|a[22:0]);
  assign b_inf = (&b[30:23]) & ~(|b[22:0]);

  always_comb begin
    x = a;
    y = b;
    if (b[30:0] > a[30:0]) begin
      x = b;
      y = a;
    end
    // denormals use exponent 1 with no hidden bit
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx = {(x[30:23] != 8'd0), x[22:0], 3'b000};
    my = {(y[30:23] != 8'd0), y[22:0], 3'b000};
    d  = ex - ey;
    if (d >= 8'd27) begin
      my_sh = 27'd0;
      stk   = |my;
    end else begin
      my_sh = my >> d;
      stk   = |(my & ((27'd1 << d) - 27'd1));
    end
    my_sh = my_sh | {26'd0, stk};

    if (x[31] ^ y[31]) s = {1'b0, mx} - {1'b0, my_sh};
    else               s = {1'b0, mx} + {1'b0, my_sh};

    e   = {2'b00, ex};
    pos = 5'd0;
    for (int i = 0; i < 27; i++)
      if (s[i]) pos = i[4:0];
    lz  = 10'd26 - {5'd0, pos};
    lim = e - 10'd1;
    sh  = (lz < lim) ? lz : lim;
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      // left shift stops at the denormal boundary
      n = s[26:0] << sh;
      e = e - sh;
    end

    up = n[2] & (n[1] | n[0] | n[3]);
    m  = {1'b0, n[26:3]} + {24'd0, up};
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'd1;
    end
    // a denormal that rounds up into bit 23 becomes the smallest normal
    expf = m[23] ? e : 10'd0;

    if (e >= 10'd255) sum = {x[31], 8'hFF, 23'd0};
    else              sum = {x[31], expf[7:0], m[22:0]};
    if (s == 28'd0)   sum = {x[31] & y[31], 31'd0};

    if (a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31]))) sum = 32'h7FC00000;
    else if (a_inf) sum = a;
    else if (b_inf) sum = b;
  end
endmodule

module fp_stream_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]      out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [31:0]      add_sum;
  logic [31:0]      res_sum;
  logic             beat;

  fp_adder_single_cycle u_add (
    .a   (acc_q),
    .b   (in_data),
    .sum (add_sum)
  );

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign beat      = in_valid & in_ready;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef FP_ACC_NAN_STICKY_EN
  logic flag_q, flag_d;
  logic beat_special;
  assign beat_special = &in_data[30:23];
  // the closing beat can itself be the special one, so fold it in here
  assign res_sum = (flag_q | beat_special) ? 32'h7FC00000 : add_sum;
  always_comb begin
    flag_d = flag_q;
    if (beat && beat_special) flag_d = 1'b1;
    if (state_q == HOLD && out_ready) flag_d = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) flag_q <= 1'b0;
    else     flag_q <= flag_d;
  end
`else
  assign res_sum = add_sum;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    case (state_q)
      IDLE, ACC: begin
        if (beat) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          if (in_last) begin
            state_d     = HOLD;
            out_sum_d   = res_sum;
            out_count_d = cnt_inc;
          end else begin
            state_d = ACC;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = 32'd0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= 32'd0;
      cnt_q       <= '0;
      out_sum_q   <= 32'd0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end
endmodule

// File: tb/tb_fp_stream_accumulator.sv
module tb_fp_stream_accumulator;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_last, out_ready;
  logic [31:0]      in_data;
  logic             in_ready, out_valid, busy;
  logic [31:0]      out_sum;
  logic [CNT_W-1:0] out_count;

  int errors = 0;
  int checks = 0;
  logic [39:0] exp_q[$];   // {sum, count}

  fp_stream_accumulator #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  // scoreboard: compare whenever a result handshake is about to happen
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("sb_sum", out_sum, e[39:8]);
        chk("sb_count", {24'd0, out_count}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0, 32'd0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_out_count", {24'd0, out_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // 98 + 169 - 89 = 178
    exp_q.push_back({32'h43320000, 8'd3});
    drive(1'b1, 32'h42C40000, 1'b0); tick();
    chk("p1_busy", {31'd0, busy}, 32'd1);
    drive(1'b1, 32'h43290000, 1'b0); tick();
    drive(1'b1, 32'hC2B20000, 1'b1);
    chk("p1_no_early_valid", {31'd0, out_valid}, 32'd0);
    tick();
    drive(1'b0, 32'd0, 1'b0);
    chk("p1_valid_latency", {31'd0, out_valid}, 32'd1);
    chk("p1_sum", out_sum, 32'h43320000);
    chk("p1_count", {24'd0, out_count}, 32'd3);
    tick();
    chk("p1_gap_valid", {31'd0, out_valid}, 32'd0);
    chk("p1_gap_ready", {31'd0, in_ready}, 32'd1);

    // single beat
    exp_q.push_back({32'h41200000, 8'd1});
    drive(1'b1, 32'h41200000, 1'b1); tick();
    drive(1'b0, 32'd0, 1'b0);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    tick();

    // backpressure: 1.0 + 2.0 = 3.0, stray beats ignored while held
    out_ready = 1'b0;
    exp_q.push_back({32'h40400000, 8'd2});
    drive(1'b1, 32'h3F800000, 1'b0); tick();
    drive(1'b1, 32'h40000000, 1'b1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h44000000, 1'b1);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_sum", out_sum, 32'h40400000);
      chk("bp_count", {24'd0, out_count}, 32'd2);
      tick();
    end
    drive(1'b0, 32'd0, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);

    // bubble mid-packet: 4.0 + 8.0 = 12.0
    exp_q.push_back({32'h41400000, 8'd2});
    drive(1'b1, 32'h40800000, 1'b0); tick();
    drive(1'b0, 32'h7F800000, 1'b0); tick();
    chk("bubble_busy", {31'd0, busy}, 32'd1);
    drive(1'b1, 32'h41000000, 1'b1); tick();
    drive(1'b0, 32'd0, 1'b0);
    chk("bubble_valid", {31'd0, out_valid}, 32'd1);
    tick();

    // reset mid-packet discards the partial sum
    drive(1'b1, 32'h42C60000, 1'b0); tick();
    drive(1'b1, 32'hC2B20000, 1'b0); tick();
    drive(1'b0, 32'd0, 1'b0);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_sum", out_sum, 32'd0);
    exp_q.push_back({32'h41200000, 8'd1});
    drive(1'b1, 32'h41200000, 1'b1); tick();
    drive(1'b0, 32'd0, 1'b0);
    chk("postrst_valid", {31'd0, out_valid}, 32'd1);
    tick();

    // Inf inside a packet
`ifdef FP_ACC_NAN_STICKY_EN
    exp_q.push_back({32'h7FC00000, 8'd3});
`else
    exp_q.push_back({32'h7F800000, 8'd3});
`endif
    drive(1'b1, 32'h3F800000, 1'b0); tick();
    drive(1'b1, 32'h7F800000, 1'b0); tick();
    drive(1'b1, 32'h40000000, 1'b1); tick();
    drive(1'b0, 32'd0, 1'b0);
    chk("inf_valid", {31'd0, out_valid}, 32'd1);
    tick();

    // count saturation: 300 zero beats
    exp_q.push_back({32'h00000000, 8'd255});
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 32'd0, (i == 299));
      tick();
    end
    drive(1'b0, 32'd0, 1'b0);
    chk("sat_valid", {31'd0, out_valid}, 32'd1);
    tick(); tick();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_stream_accumulator.md
# fp_stream_accumulator

Streaming FP32 accumulator that sits directly downstream of operand sources and upstream of result consumers, wrapping one `fp_adder_single_cycle` instance in a feedback loop. It accepts a packet of IEEE-754 single-precision values over a valid/ready stream, delimited by `in_last`. It sums them as `acc = acc + x` in arrival order, using the adder's combinational path once per accepted beat. It then presents the packet total and beat count on a registered valid/ready output.

## Interface
- `CNT_W`, default 8: width of the beat counter; the count saturates at 2^CNT_W-1.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_data`  in  32  FP32 operand.
- `in_last`  in  1  marks the final beat of a packet.
- `out_valid`  out  1  packet result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  32  FP32 packet total.
- `out_count`  out  CNT_W  number of beats in the packet, saturating.
- `busy`  out  1  packet in progress (state ACC or HOLD).

## Operation
- States:
  - IDLE: acc=0, cnt=0.
  - ACC: mid-packet.
  - HOLD: result presented.
- Adder instance: `a` = acc register, `b` = `in_data`, combinational `sum` = next acc.
- Beat accepted when `in_valid && in_ready`:
  - acc <= adder sum.
  - cnt <= cnt+1, saturating at all-ones.
- Transitions:
  - IDLE, beat without last -> ACC.
  - IDLE or ACC, beat with last -> HOLD; `out_sum` <= adder sum; `out_count` <= cnt+1 (saturating); `out_valid` <= 1.
  - ACC, no beat -> stays in ACC; acc and cnt hold.
  - HOLD, `out_valid && out_ready` -> IDLE; acc <= 0; cnt <= 0; `out_valid` <= 0.
  - HOLD, no handshake -> stays in HOLD; all outputs stable.
- `in_ready` = (state != HOLD). No beat is accepted in HOLD.
- A single-beat packet yields `out_sum` = 0 + x, with zero handling as defined by the adder.
- Arithmetic exceptions, rounding and zero handling are whatever the adder produces. The block adds no rounding of its own.
- Reset mid-packet or in HOLD: the partial sum and any pending result are discarded, with no output.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_sum` = 32'h0.
  - `out_count` = 0.
  - `busy` = 0.
  - State = IDLE.
- Throughput: one beat per cycle within a packet.
- Latency: `out_valid` rises in the cycle after the `in_last` beat is accepted.
- Packet gap: the cycle after the output handshake is IDLE with `in_ready`=1. The minimum packet-to-packet gap is therefore 1 cycle plus the consumer stall.
- `out_sum` and `out_count` are registered and stable while `out_valid`=1 and `out_ready`=0.
- `in_valid` deasserted mid-packet: the bubble is allowed and the accumulator holds.
- `rst` has priority over every handshake in the same cycle.

## Configuration
- Macro: `FP_ACC_NAN_STICKY_EN`.
- Defined:
  - A sticky flag is set by any accepted beat whose exponent is 8'hFF, meaning Inf or NaN.
  - In HOLD with the flag set, `out_sum` = 32'h7FC00000.
  - The flag clears on reset and on the output handshake.
- Undefined:
  - No flag exists.
  - Exponent-255 inputs pass through the adder unmodified.

## Test plan
- Reset, then idle: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `busy`=0.
- Packet {98.0 (0x42C40000), 169.0 (0x43290000), last -89.0 (0xC2B20000)} on consecutive cycles, `out_ready`=1:
  - `out_valid` is high exactly 1 cycle after the last beat.
  - `out_sum`=0x43320000 (178.0), `out_count`=3.
- Single-beat packet 10.0 (0x41200000) with `in_last`=1: `out_sum`=0x41200000, `out_count`=1.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles after a result: `out_sum` and `out_count` stay stable, `in_ready`=0, and `in_valid` beats are ignored.
  - Release `out_ready`: the next cycle shows `out_valid`=0 and `in_ready`=1.
- Assert `rst` after 2 beats of {99.0, -89.0}, then send packet {10.0 last]:
  - No output is produced for the first packet.
  - The second packet gives `out_sum`=0x41200000, `out_count`=1.
- With `FP_ACC_NAN_STICKY_EN` defined, send packet {1.0, 0x7F800000, last 2.0}: `out_sum`=0x7FC00000. Without the macro, the result equals the adder chain output.
